alu_op_sequencer: RTL and testbench

//  Multi-cycle initiator that drives the datapath ALU (op 00 ADD, 01 SUB A-B, 10 AND, 11 NOT B).

---
 rtl/alu_op_sequencer_if.sv | 25 ++
 rtl/alu_op_sequencer.sv | 137 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Request channel between the decode/control FSM (master) and alu_op_sequencer (slave).
// Transfer happens on a rising edge where req_valid and req_ready are both high.
interface alu_op_sequencer_if #(
  parameter int DW   = 16,
  parameter int NREG = 8
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_mov;
  logic [1:0]              req_op;
  logic [$clog2(NREG)-1:0] req_rd;
  logic [$clog2(NREG)-1:0] req_rn;
  logic [$clog2(NREG)-1:0] req_rm;
  logic [DW-1:0]           req_imm;

  modport master (
    output req_valid, req_mov, req_op, req_rd, req_rn, req_rm, req_imm,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_mov, req_op, req_rd, req_rn, req_rm, req_imm,
    output req_ready
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU initiator with an internal register file; one request in flight at a time.
// Optional macro ALU_SEQ_NV_FLAGS_EN adds V/N status tracking (default build tracks Z only).
module alu_op_sequencer #(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  alu_op_sequencer_if.slave       req,
  output logic [DW-1:0]           alu_ain,
  output logic [DW-1:0]           alu_bin,
  output logic [1:0]              alu_op,
  input  logic [DW-1:0]           alu_out,
  input  logic                    alu_z,
  output logic                    done,
  output logic [2:0]              status,
  input  logic [$clog2(NREG)-1:0] dbg_sel,
  output logic [DW-1:0]           dbg_data,
  output logic [2:0]              dbg_state
);
  localparam int IW = $clog2(NREG);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_EXEC  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            w_accept;
  logic [IW-1:0]   r_rd;
  logic [IW-1:0]   r_rn;
  logic [IW-1:0]   r_rm;
  logic [1:0]      r_op;
  logic [DW-1:0]   r_c;
  logic            r_z;
  logic [DW-1:0]   r_regs [NREG];

  // Handshake: a request transfers on a rising edge where req_valid & req_ready;
  // req_ready is high only in IDLE (and therefore throughout reset).
  assign req.req_ready = (r_state == S_IDLE);
  assign w_accept      = req.req_valid && (r_state == S_IDLE);
  assign done          = (r_state == S_DONE);
  assign dbg_data      = r_regs[dbg_sel];
  assign dbg_state     = r_state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = req.req_mov ? S_WRITE : S_LOAD;
      S_LOAD:  w_next = S_EXEC;
      S_EXEC:  w_next = S_WRITE;
      S_WRITE: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operands are sampled in LOAD, so rd == rn/rm cannot disturb the op in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd    <= '0;
      r_rn    <= '0;
      r_rm    <= '0;
      r_op    <= '0;
      r_c     <= '0;
      r_z     <= 1'b0;
      alu_ain <= '0;
      alu_bin <= '0;
      alu_op  <= '0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rd <= req.req_rd;
            r_rn <= req.req_rn;
            r_rm <= req.req_rm;
            r_op <= req.req_op;
            if (req.req_mov) r_c <= req.req_imm;
          end
        end
        S_LOAD: begin
          alu_ain <= r_regs[r_rn];
          alu_bin <= r_regs[r_rm];
          alu_op  <= r_op;
        end
        S_EXEC: begin
          r_c <= alu_out;
          r_z <= alu_z;
        end
        S_WRITE: r_regs[r_rd] <= r_c;
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_NV_FLAGS_EN
  logic r_v;
  logic r_n;
  logic w_v;

  // Signed overflow: ADD overflows when like-signed operands give a differently signed result,
  // SUB when the operand signs differ and the result sign departs from A.
  always_comb begin
    w_v = 1'b0;
    case (alu_op)
      2'b00:   w_v = (alu_ain[DW-1] == alu_bin[DW-1]) && (alu_out[DW-1] != alu_ain[DW-1]);
      2'b01:   w_v = (alu_ain[DW-1] != alu_bin[DW-1]) && (alu_out[DW-1] != alu_ain[DW-1]);
      default: w_v = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v <= 1'b0;
      r_n <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_v <= w_v;
      r_n <= alu_out[DW-1];
    end
  end

  assign status = {r_v, r_n, r_z};
`else
  assign status = {2'b00, r_z};
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed plus randomized bench for alu_op_sequencer with an environment ALU and a
// register-file reference model computed from signed/unsigned integer arithmetic.
module tb_alu_op_sequencer;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.DW(DW), .NREG(8)) req_if ();

  logic [DW-1:0] alu_ain, alu_bin, alu_out, dbg_data;
  logic [1:0]    alu_op;
  logic          alu_z, done;
  logic [2:0]    status, dbg_sel, dbg_state;

  alu_op_sequencer #(.DW(DW), .NREG(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req_if),
    .alu_ain   (alu_ain),
    .alu_bin   (alu_bin),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .alu_z     (alu_z),
    .done      (done),
    .status    (status),
    .dbg_sel   (dbg_sel),
    .dbg_data  (dbg_data),
    .dbg_state (dbg_state)
  );

  // Combinational datapath ALU the sequencer drives.
  always_comb begin
    case (alu_op)
      2'b00:   alu_out = alu_ain + alu_bin;
      2'b01:   alu_out = alu_ain - alu_bin;
      2'b10:   alu_out = alu_ain & alu_bin;
      default: alu_out = ~alu_bin;
    endcase
    alu_z = (alu_out == '0);
  end

  // ---------------- monitors ----------------
  int acc_cnt  = 0;
  int done_cnt = 0;
  always @(posedge clk) begin
    if (reset_n && req_if.req_valid && req_if.req_ready) acc_cnt++;
    if (done === 1'b1) done_cnt++;
  end

  // ---------------- scoreboard / reference model ----------------
  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_regs [8];
  logic          m_v, m_n, m_z;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_status();
`ifdef ALU_SEQ_NV_FLAGS_EN
    return {m_v, m_n, m_z};
`else
    return {2'b00, m_z};
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_v = 1'b0; m_n = 1'b0; m_z = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_op(input bit mov, input logic [1:0] op, input logic [2:0] rd,
                          input logic [2:0] rn, input logic [2:0] rm,
                          input logic [DW-1:0] imm, output logic [DW-1:0] res);
    int sa, sb, s;
    logic [DW-1:0] a, b;
    if (mov) begin
      res = imm;
    end else begin
      a  = m_regs[rn];
      b  = m_regs[rm];
      sa = int'($signed(a));
      sb = int'($signed(b));
      m_v = 1'b0;
      case (op)
        2'b00: begin s = sa + sb; res = DW'(s); m_v = (s > 32767) || (s < -32768); end
        2'b01: begin s = sa - sb; res = DW'(s); m_v = (s > 32767) || (s < -32768); end
        2'b10: res = a & b;
        default: res = ~b;
      endcase
      m_z = (res == '0);
      m_n = res[DW-1];
    end
    m_regs[rd] = res;
  endtask

  // ---------------- driver ----------------
  task automatic run_op(input bit mov, input logic [1:0] op, input logic [2:0] rd,
                        input logic [2:0] rn, input logic [2:0] rm,
                        input logic [DW-1:0] imm, input bit hold);
    logic [DW-1:0] a, b, res;
    int cyc, acc0;
    a = m_regs[rn];
    b = m_regs[rm];
    model_op(mov, op, rd, rn, rm, imm, res);
    exp_q.push_back(res);
    @(negedge clk);
    check("ready_before", 32'(req_if.req_ready), 32'd1);
    req_if.req_mov = mov; req_if.req_op = op; req_if.req_rd = rd;
    req_if.req_rn = rn; req_if.req_rm = rm; req_if.req_imm = imm;
    req_if.req_valid = 1'b1;
    dbg_sel = rd;
    acc0 = acc_cnt;
    @(negedge clk);
    cyc = 1;
    if (!hold) req_if.req_valid = 1'b0;
    while (done !== 1'b1 && cyc < 12) begin
      if (!mov && cyc == 2) begin
        check("exec_ain", 32'(alu_ain), 32'(a));
        check("exec_bin", 32'(alu_bin), 32'(b));
        check("exec_op", 32'(alu_op), 32'(op));
      end
      @(negedge clk);
      cyc++;
    end
    check("done_latency", cyc, mov ? 32'd2 : 32'd4);
    req_if.req_valid = 1'b0;
    check("wb_data", 32'(dbg_data), 32'(exp_q.pop_front()));
    check("status", 32'(status), 32'(exp_status()));
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    check("ready_after", 32'(req_if.req_ready), 32'd1);
    check("accepts", acc_cnt - acc0, 32'd1);
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i);
      #1;
      check(tag, 32'(dbg_data), 32'(m_regs[i]));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    req_if.req_valid = 1'b0; req_if.req_mov = 1'b0; req_if.req_op = '0;
    req_if.req_rd = '0; req_if.req_rn = '0; req_if.req_rm = '0; req_if.req_imm = '0;
    dbg_sel = '0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_if.req_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_status", 32'(status), 32'd0);
    check("rst_ain", 32'(alu_ain), 32'd0);
    check("rst_bin", 32'(alu_bin), 32'd0);
    check("rst_op", 32'(alu_op), 32'd0);
    reset_n = 1'b1;
    check_all_regs("rst_reg");

    // ADD of two equal negatives
    run_op(1, 2'b00, 3'd0, 3'd0, 3'd0, 16'hF0CF, 0);
    run_op(1, 2'b00, 3'd1, 3'd0, 3'd0, 16'hF0CF, 0);
    run_op(0, 2'b00, 3'd2, 3'd0, 3'd1, 16'h0000, 0);
    dbg_sel = 3'd2; #1;
    check("add_const", 32'(dbg_data), 32'h0000E19E);

    // SUB to zero, then MOV keeps the flags
    run_op(0, 2'b01, 3'd3, 3'd0, 3'd1, 16'h0000, 0);
    check("sub_z", 32'(status[0]), 32'd1);
    run_op(1, 2'b00, 3'd3, 3'd0, 3'd0, 16'h1234, 0);
    check("mov_keeps_z", 32'(status[0]), 32'd1);

    // AND / NOT
    run_op(0, 2'b10, 3'd4, 3'd0, 3'd1, 16'h0000, 0);
    run_op(0, 2'b11, 3'd5, 3'd0, 3'd1, 16'h0000, 0);
    dbg_sel = 3'd5; #1;
    check("not_const", 32'(dbg_data), 32'h00000F30);

    // Signed overflow with rd == rn
    run_op(1, 2'b00, 3'd6, 3'd0, 3'd0, 16'h7FFF, 0);
    run_op(1, 2'b00, 3'd7, 3'd0, 3'd0, 16'h0001, 0);
    run_op(0, 2'b00, 3'd6, 3'd6, 3'd7, 16'h0000, 0);
    dbg_sel = 3'd6; #1;
    check("ovf_const", 32'(dbg_data), 32'h00008000);

    // req_valid held through a busy op
    run_op(0, 2'b00, 3'd2, 3'd0, 3'd1, 16'h0000, 1);
    check_all_regs("reg_snapshot");

    // Reset while in EXEC: abort without writeback or done
    @(negedge clk);
    req_if.req_mov = 1'b0; req_if.req_op = 2'b00; req_if.req_rd = 3'd1;
    req_if.req_rn = 3'd0; req_if.req_rm = 3'd1; req_if.req_valid = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    req_if.req_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_ready", 32'(req_if.req_ready), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    check("abort_status", 32'(status), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 32'd0);
    check_all_regs("abort_reg");

    // Randomized mix
    for (int k = 0; k < 40; k++) begin
      logic [DW-1:0] imm;
      imm = DW'($urandom);
      if ($urandom_range(0, 2) == 0) imm = ($urandom_range(0, 1) == 0) ? 16'h7FFF : 16'h8000;
      run_op($urandom_range(0, 9) < 4, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
             3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), imm,
             $urandom_range(0, 4) == 0);
    end
    check_all_regs("final_reg");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    n_err++;
    $display("FAIL timeout observed=running expected=finished");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "simulation time limit reached");
  end
endmodule
